// File: rtl/shift_seq.sv
// shift_seq: sequential barrel-free shifter.
//
// An accepted request latches the operand, opcode, shift amount and sign bit.
// The operand is then shifted one step per cycle in an internal working
// register until the remaining count reaches zero. The final value is
// presented on result together with a one-cycle done pulse.
//
// Optional build macro:
//   SHIFT_SEQ_FAST_EN - while at least 4 bits remain, each step shifts by 4
//                       bits instead of 1.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst    - synchronous, active-high reset
//   start  - request to begin an operation (honoured in IDLE or DONE only)
//   op     - 00 logical right, 01 logical left, 10 arithmetic right,
//            11 arithmetic left (same as 01)
//   A      - 32-bit operand
//   num    - shift amount, 0..31
//   busy   - high while shifting
//   done   - one-cycle pulse, result valid
//   result - registered final shift result, held until the next completion
module shift_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [4:0]  num,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] work;      // working register, holds intermediate values
  logic [31:0] work_shf;  // working register after one step
  logic [4:0]  cnt;       // remaining shift amount
  logic [4:0]  cnt_nxt;
  logic [4:0]  step;
  logic        step4;     // current step moves four bits
  logic [1:0]  op_q;
  logic        sign_q;
  logic        accept;

  // A new request is taken only outside SHIFT, so a running operation and its
  // latched operands are never disturbed.
  assign accept = start && (state != SHIFT);

  // Step size selection.
`ifdef SHIFT_SEQ_FAST_EN
  assign step4 = (cnt >= 5'd4);
`else
  assign step4 = 1'b0;
`endif

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    step    = 5'd1;
    if (step4) begin
      step = 5'd4;
    end
    cnt_nxt = cnt - step;
  end

  // One shift step. Arithmetic right fills from the sign latched at
  // acceptance, not from the working register's current MSB.
  always_comb begin
    work_shf = work;
    case (op_q)
      2'b00:   work_shf = step4 ? {4'b0000, work[31:4]} : {1'b0, work[31:1]};
      2'b10:   work_shf = step4 ? {{4{sign_q}}, work[31:4]} : {sign_q, work[31:1]};
      default: work_shf = step4 ? {work[27:0], 4'b0000} : {work[30:0], 1'b0};
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          state_nxt = (num == 5'd0) ? DONE : SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt_nxt == 5'd0) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, working register, count and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      work   <= '0;
      cnt    <= '0;
      op_q   <= '0;
      sign_q <= 1'b0;
      result <= '0;
    end else if (accept) begin
      work   <= A;
      cnt    <= num;
      op_q   <= op;
      sign_q <= A[31];
      // A zero-length shift completes immediately with the operand itself.
      if (num == 5'd0) begin
        result <= A;
      end
    end else if (state == SHIFT) begin
      work <= work_shf;
      cnt  <= cnt_nxt;
      // result changes only on the final step so it stays stable while busy.
      if (cnt_nxt == 5'd0) begin
        result <= work_shf;
      end
    end
  end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request to begin a shift operation.
REQ-004 SHALL have port op, input, 2 bits: 00 logical right, 01 logical left, 10 arithmetic right, 11 arithmetic left (same result as 01).
REQ-005 SHALL have port A, input, 32 bits: operand.
REQ-006 SHALL have port num, input, 5 bits: shift amount, 0..31.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: single-cycle pulse marking result valid.
REQ-009 SHALL have port result, output, 32 bits: registered shift result.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-011 SHALL accept start only in IDLE or DONE; acceptance latches A, op, num and the sign bit A[31].
REQ-012 SHALL ignore start while in SHIFT, with no effect on the operation in progress or its latched operands.
REQ-013 SHALL, on acceptance with num=0, go directly to DONE; result=A on the next cycle.
REQ-014 SHALL, on acceptance with num!=0, go to SHIFT with the remaining count set to num.
REQ-015 SHALL, in SHIFT, shift the working register by one step per cycle and decrement the remaining count by the step size (1 bit by default; see REQ-025).
REQ-016 SHALL fill vacated bits as follows: op 00 zero-fill from the MSB side; op 01/11 zero-fill from the LSB side; op 10 fill from the MSB side with the latched sign bit.
REQ-017 SHALL go to DONE on the cycle after the step that brings the remaining count to 0.
REQ-018 SHALL set latency: start accepted at cycle t gives done=1 at cycle t+1+S, where S = number of steps (S=num by default, S=0 when num=0).
REQ-019 SHALL assert busy=1 exactly while in SHIFT, and busy=0 in IDLE and DONE.
REQ-020 SHALL assert done=1 only in DONE, for exactly one cycle per accepted operation.
REQ-021 SHALL present result equal to the final shifted value in DONE, and hold it until the next operation completes or reset.
REQ-022 SHALL move from DONE to IDLE when start=0, and to SHIFT or DONE per REQ-013/014 when start=1, giving back-to-back operation with no idle gap.
REQ-023 SHALL keep result stable during SHIFT; intermediate values live only in the internal working register.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, set state to IDLE, busy=0, done=0, result=0 and clear the working register and count; rst overrides start, and an operation aborted by reset SHALL produce no done pulse.

Configuration
REQ-025 SHALL support macro SHIFT_SEQ_FAST_EN: when defined, the step is 4 bits while the remaining count is >=4 and 1 bit otherwise, so S = num/4 + num%4; when undefined, the step is always 1 bit and S = num; fill rules and the handshake are identical in both builds.

Verification
REQ-026 SHALL cover: A=0x80000001, op=10, num=4 -> done at t+5 (default) or t+2 (FAST), result=0xF8000000, busy high for 4 or 1 cycles respectively.
REQ-027 SHALL cover: A=0x0000000F, op=01, num=31 -> result=0x80000000; done at t+32 (default) or t+11 (FAST).
REQ-028 SHALL cover: A=0x12345678, op=00, num=0 -> done at t+1, result=0x12345678, busy never high.
REQ-029 SHALL cover: start pulsed during SHIFT with different A -> ignored, original result delivered; then start asserted in the DONE cycle -> second operation accepted with no idle cycle.
REQ-030 SHALL cover: rst=1 mid-SHIFT (A=0xFFFF0000, op=00, num=16) -> next cycle IDLE, result=0, busy=0, no done pulse.
